// File: rtl/tdc_hit_encoder_pkg.sv
// tdc_hit_encoder_pkg
//   Constants, the timestamp record and the fine-code priority encoder that
//   are shared by the TDC hit encoder and its timestamp FIFO.
//   Timestamp word layout (LSB first): fine[FINE_W-1:0], coarse[coarse_w-1:0], err.
package tdc_hit_encoder_pkg;

   localparam int FINE_W       = 5;   // binary fine code width
   localparam int SNAP_W       = 32;  // fine-time snapshot width
   localparam int COARSE_MAX_W = 24;  // widest supported coarse counter

   // Field offsets inside a packed timestamp word.
   localparam int TS_FINE_LSB   = 0;
   localparam int TS_COARSE_LSB = FINE_W;

   function automatic int ts_err_bit(input int coarse_w);
      return FINE_W + coarse_w;
   endfunction

   // Coarse is carried at maximum width; the top keeps only COARSE_W bits.
   typedef struct packed {
      logic                    err;
      logic [COARSE_MAX_W-1:0] coarse;
      logic [FINE_W-1:0]       fine;
   } ts_t;

   // Index of the highest set bit; 0 for an all-zero snapshot (the caller
   // flags that case separately as an error).
   function automatic logic [FINE_W-1:0] prio_enc(input logic [SNAP_W-1:0] v);
      logic [FINE_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < SNAP_W; i++) begin
         if (v[i]) idx = FINE_W'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/tdc_ts_fifo.sv
// tdc_ts_fifo
//   Synchronous timestamp FIFO. A push while full is still accepted when the
//   head is popped in the same cycle; otherwise the push is reported on drop_o.
//   Ports:
//     clk, rst_n   clock, asynchronous active-low reset
//     push_i       write request, wdata_i its data
//     ready_i      consumer accepts head (pop = valid_o & ready_i)
//     valid_o      head valid; rdata_o head data (zero while empty)
//     level_o      entries held
//     drop_o       push rejected this cycle (full, no pop)
module tdc_ts_fifo #(
   parameter int W     = 22,
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push_i,
   input  logic [W-1:0]               wdata_i,
   input  logic                       ready_i,
   output logic                       valid_o,
   output logic [W-1:0]               rdata_o,
   output logic [$clog2(DEPTH):0]     level_o,
   output logic                       drop_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d;
   logic          full, empty, pop, wr_en;

   assign full  = (level_q == LW'(DEPTH));
   assign empty = (level_q == '0);
   assign pop   = ~empty & ready_i;
   // A pop frees the head slot in the same cycle, so a full FIFO can still take a write.
   assign wr_en  = push_i & (~full | pop);
   assign drop_o = push_i & full & ~pop;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      // DEPTH is a power of two, so pointers wrap by natural overflow.
      if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)   rd_ptr_d = rd_ptr_q + AW'(1);
      case ({wr_en, pop})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Storage needs no reset: the read side is gated by the level.
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q] <= wdata_i;
   end

   assign valid_o = ~empty;
   assign rdata_o = empty ? '0 : mem_q[rd_ptr_q];
   assign level_o = level_q;

endmodule

// File: rtl/tdc_hit_encoder.sv
// tdc_hit_encoder
//   Turns 32-bit fine-time snapshots into {err, coarse, fine} timestamps and
//   queues them for readout. Three stages: capture, encode, store.
//   Ports:
//     clk, rst_n      system clock, asynchronous active-low reset
//     enable          runs the coarse counter and accepts hits
//     hit_valid       one-cycle strobe qualifying thermo
//     thermo          fine-time snapshot
//     ts_valid/ts_ready/ts_data   timestamp readout
//     fifo_level      entries held in the FIFO
//     overflow        sticky, a timestamp was dropped
//     drop_count      dropped timestamps, saturating at 255
//     clr_overflow    clears overflow and drop_count
//
// Readout handshake: ts_data carries the head entry whenever ts_valid=1; the
// head is removed at the clock edge where ts_valid & ts_ready are both high,
// and ts_data is held unchanged while ts_valid=1 and ts_ready=0. ts_ready may
// depend on ts_valid; ts_valid never depends on ts_ready.
module tdc_hit_encoder
   import tdc_hit_encoder_pkg::*;
#(
   parameter int COARSE_W   = 16,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           enable,
   input  logic                           hit_valid,
   input  logic [SNAP_W-1:0]              thermo,
   output logic                           ts_valid,
   input  logic                           ts_ready,
   output logic [COARSE_W+FINE_W:0]       ts_data,
   output logic [$clog2(FIFO_DEPTH):0]    fifo_level,
   output logic                           overflow,
   output logic [7:0]                     drop_count,
   input  logic                           clr_overflow
);

   localparam int TS_W = COARSE_W + FINE_W + 1;

   logic [COARSE_W-1:0] coarse_q, coarse_d;
   logic                s1_vld_q, s1_vld_d;
   logic [SNAP_W-1:0]   s1_thermo_q, s1_thermo_d;
   logic [COARSE_W-1:0] s1_coarse_q, s1_coarse_d;
   logic                s2_vld_q, s2_vld_d;
   ts_t                 s2_q, s2_d;
   logic                overflow_q, overflow_d;
   logic [7:0]          drop_cnt_q, drop_cnt_d;
   logic                fifo_drop;
   logic [TS_W-1:0]     ts_word;

   always_comb begin
      coarse_d    = enable ? coarse_q + COARSE_W'(1) : coarse_q;

      // Capture the coarse count of the hit cycle itself, not of the write cycle.
      s1_vld_d    = hit_valid & enable;
      s1_thermo_d = s1_vld_d ? thermo : s1_thermo_q;
      s1_coarse_d = s1_vld_d ? coarse_q : s1_coarse_q;

      s2_vld_d    = s1_vld_q;
      s2_d        = s2_q;
      if (s1_vld_q) begin
         s2_d.err    = ~|s1_thermo_q;
         s2_d.coarse = COARSE_MAX_W'(s1_coarse_q);
         s2_d.fine   = prio_enc(s1_thermo_q);
      end

      // Clear applies first so that a drop in the same cycle still shows up.
      overflow_d = clr_overflow ? 1'b0 : overflow_q;
      drop_cnt_d = clr_overflow ? 8'd0 : drop_cnt_q;
      if (fifo_drop) begin
         overflow_d = 1'b1;
         if (drop_cnt_d != 8'hFF) drop_cnt_d = drop_cnt_d + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         coarse_q    <= '0;
         s1_vld_q    <= 1'b0;
         s1_thermo_q <= '0;
         s1_coarse_q <= '0;
         s2_vld_q    <= 1'b0;
         s2_q        <= '0;
         overflow_q  <= 1'b0;
         drop_cnt_q  <= '0;
      end else begin
         coarse_q    <= coarse_d;
         s1_vld_q    <= s1_vld_d;
         s1_thermo_q <= s1_thermo_d;
         s1_coarse_q <= s1_coarse_d;
         s2_vld_q    <= s2_vld_d;
         s2_q        <= s2_d;
         overflow_q  <= overflow_d;
         drop_cnt_q  <= drop_cnt_d;
      end
   end

   assign ts_word = {s2_q.err, s2_q.coarse[COARSE_W-1:0], s2_q.fine};

   // Coarse bits above COARSE_W are always zero and never leave the block.
   if (COARSE_W < COARSE_MAX_W) begin : g_coarse_hi
      logic unused_coarse_hi;
      assign unused_coarse_hi = ^s2_q.coarse[COARSE_MAX_W-1:COARSE_W];
   end

   tdc_ts_fifo #(
      .W     (TS_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (s2_vld_q),
      .wdata_i (ts_word),
      .ready_i (ts_ready),
      .valid_o (ts_valid),
      .rdata_o (ts_data),
      .level_o (fifo_level),
      .drop_o  (fifo_drop)
   );

   assign overflow   = overflow_q;
   assign drop_count = drop_cnt_q;

endmodule

// File: tb/tb_tdc_hit_encoder.sv
module tb_tdc_hit_encoder;

   localparam int CW    = 8;
   localparam int DEPTH = 8;
   localparam int DW    = CW + 6;
   localparam int LW    = $clog2(DEPTH) + 1;

   // ---------------- clock / reset / DUT ----------------
   logic          clk = 1'b0;
   logic          rst_n;
   logic          enable, hit_valid, ts_ready, clr_overflow;
   logic [31:0]   thermo;
   logic          ts_valid, overflow;
   logic [DW-1:0] ts_data;
   logic [LW-1:0] fifo_level;
   logic [7:0]    drop_count;

   always #5 clk = ~clk;

   tdc_hit_encoder #(.COARSE_W(CW), .FIFO_DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .enable       (enable),
      .hit_valid    (hit_valid),
      .thermo       (thermo),
      .ts_valid     (ts_valid),
      .ts_ready     (ts_ready),
      .ts_data      (ts_data),
      .fifo_level   (fifo_level),
      .overflow     (overflow),
      .drop_count   (drop_count),
      .clr_overflow (clr_overflow)
   );

   // ---------------- checking helpers ----------------
   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   // ---------------- reference model ----------------
   // exp_q is both the scoreboard and the model of the FIFO contents.
   typedef struct { int due; logic [DW-1:0] data; } pend_t;
   logic [DW-1:0] exp_q[$];
   pend_t         pipe_q[$];
   pend_t         pend_p;
   int            edge_n   = 0;
   int            coarse_m = 0;
   int            occ_m;
   bit            pop_flag = 0;
   bit            ov_m     = 0;
   int            dc_m     = 0;
   logic [DW-1:0] mon_exp;

   // Fine code = floor(log2(thermo)); empty snapshot flags an error.
   function automatic logic [DW-1:0] ref_ts(input logic [31:0] th, input int coarse);
      logic err;
      int   fine;
      logic [CW-1:0] c;
      err  = (th == 32'd0);
      fine = err ? 0 : $clog2({1'b0, th} + 33'd1) - 1;
      c    = coarse[CW-1:0];
      return {err, c, fine[4:0]};
   endfunction

   always @(posedge clk) begin
      if (rst_n) begin
         edge_n++;
         occ_m = exp_q.size() + int'(pop_flag);
         if (clr_overflow) begin
            ov_m = 0;
            dc_m = 0;
         end
         while (pipe_q.size() > 0 && pipe_q[0].due == edge_n) begin
            pend_p = pipe_q.pop_front();
            if (occ_m < DEPTH || pop_flag) exp_q.push_back(pend_p.data);
            else begin
               ov_m = 1;
               if (dc_m < 255) dc_m++;
            end
         end
         if (hit_valid && enable) pipe_q.push_back('{edge_n + 2, ref_ts(thermo, coarse_m)});
         if (enable) coarse_m = (coarse_m + 1) % (1 << CW);
         pop_flag = 0;
      end
   end

   // Monitor: compares visible state and pops the scoreboard on every handshake.
   always @(negedge clk) begin
      if (rst_n) begin
         check("ts_valid", ts_valid, exp_q.size() != 0);
         check("fifo_level", fifo_level, exp_q.size());
         check("overflow", overflow, ov_m);
         check("drop_count", drop_count, dc_m);
         if (ts_ready && exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            check("ts_data", ts_data, mon_exp);
            pop_flag = 1;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit hv, input logic [31:0] th);
      hit_valid = hv;
      thermo    = th;
      step();
      hit_valid = 1'b0;
   endtask

   task automatic wait_coarse(input int v);
      for (int g = 0; g < 600 && coarse_m != v; g++) step();
   endtask

   task automatic drain();
      ts_ready = 1'b1;
      for (int g = 0; g < 64 && (exp_q.size() != 0 || pipe_q.size() != 0); g++) step();
      step();
      check("drain_level", fifo_level, 0);
      check("drain_valid", ts_valid, 0);
   endtask

   task automatic clear_ov();
      clr_overflow = 1'b1;
      step();
      clr_overflow = 1'b0;
      check("clr_overflow", overflow, 0);
      check("clr_drop_count", drop_count, 0);
   endtask

   function automatic logic [31:0] rand_thermo();
      logic [32:0] t;
      int k;
      k = $urandom_range(0, 31);
      case ($urandom_range(0, 3))
         0:       t = 33'd0;
         1:       t = 33'd1 << k;
         2:       t = (33'd1 << (k + 1)) - 33'd1;
         default: t = {1'b0, 32'($urandom)};
      endcase
      return t[31:0];
   endfunction

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      rst_n = 1'b0; enable = 1'b0; hit_valid = 1'b0; thermo = '0;
      ts_ready = 1'b0; clr_overflow = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_ts_valid", ts_valid, 0);
      check("rst_ts_data", ts_data, 0);
      check("rst_fifo_level", fifo_level, 0);
      check("rst_overflow", overflow, 0);
      check("rst_drop_count", drop_count, 0);
      rst_n = 1'b1;

      // Single hit at coarse 5, ts_valid three cycles later.
      ts_ready = 1'b1;
      enable   = 1'b1;
      wait_coarse(5);
      drive(1'b1, 32'h0000_0F00);
      check("t1_valid_n1", ts_valid, 0);
      step();
      check("t1_valid_n2", ts_valid, 0);
      step();
      check("t1_valid_n3", ts_valid, 1);
      check("t1_data", ts_data, {1'b0, 8'd5, 5'd11});

      // Empty snapshot at coarse 20.
      wait_coarse(20);
      drive(1'b1, 32'd0);
      step();
      step();
      check("t2_valid", ts_valid, 1);
      check("t2_data", ts_data, {1'b1, 8'd20, 5'd0});

      // Burst of 10 into a stalled FIFO, then drain in order.
      drain();
      ts_ready = 1'b0;
      for (int i = 0; i < 10; i++) drive(1'b1, rand_thermo());
      repeat (4) step();
      check("t3_level", fifo_level, 8);
      check("t3_overflow", overflow, 1);
      check("t3_drop_count", drop_count, 2);
      drain();
      clear_ov();

      // Full FIFO with a pop in the arrival cycle: no drop.
      ts_ready = 1'b0;
      for (int i = 0; i < 8; i++) drive(1'b1, rand_thermo());
      repeat (4) step();
      check("t4_full", fifo_level, 8);
      drive(1'b1, rand_thermo());
      step();
      ts_ready = 1'b1;
      step();
      ts_ready = 1'b0;
      check("t4_level", fifo_level, 8);
      check("t4_overflow", overflow, 0);

      // Three drops, then a drop coinciding with clear, then saturation.
      for (int i = 0; i < 3; i++) drive(1'b1, rand_thermo());
      repeat (3) step();
      check("t5_drop3", drop_count, 3);
      drive(1'b1, rand_thermo());
      step();
      clr_overflow = 1'b1;
      step();
      clr_overflow = 1'b0;
      check("t5_clr_drop_ov", overflow, 1);
      check("t5_clr_drop_cnt", drop_count, 1);
      for (int i = 0; i < 300; i++) drive(1'b1, rand_thermo());
      repeat (3) step();
      check("t5_saturate", drop_count, 255);
      check("t5_sat_ov", overflow, 1);
      clear_ov();
      drain();

      // Coarse wrap: hits at 255 and 0.
      wait_coarse(255);
      drive(1'b1, rand_thermo());
      drive(1'b1, rand_thermo());
      step();
      check("t6_coarse_255", ts_data[CW+4:5], 255);
      step();
      check("t6_coarse_0", ts_data[CW+4:5], 0);
      drain();

      // Reset in the middle of a burst.
      ts_ready = 1'b0;
      for (int i = 0; i < 6; i++) drive(1'b1, rand_thermo());
      rst_n = 1'b0;
      #1;
      check("t7_rst_valid", ts_valid, 0);
      check("t7_rst_level", fifo_level, 0);
      check("t7_rst_data", ts_data, 0);
      exp_q.delete();
      pipe_q.delete();
      coarse_m = 0; ov_m = 0; dc_m = 0; pop_flag = 0;
      step();
      step();
      rst_n    = 1'b1;
      ts_ready = 1'b1;
      repeat (6) step();
      check("t7_no_stale", ts_valid, 0);
      wait_coarse(3);
      drive(1'b1, 32'h8000_0000);
      step();
      step();
      check("t7_after_rst", ts_data, {1'b0, 8'd3, 5'd31});

      // Randomised traffic with enable gaps, back-pressure and clears.
      for (int i = 0; i < 400; i++) begin
         enable       = ($urandom_range(0, 7) != 0);
         ts_ready     = ($urandom_range(0, 3) != 0);
         clr_overflow = ($urandom_range(0, 15) == 0);
         drive(1'($urandom_range(0, 1)), rand_thermo());
      end
      enable       = 1'b1;
      clr_overflow = 1'b0;
      drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
